// File: rtl/audio_level_meter.sv
`default_nettype none
// ============================================================================
// Module      : audio_level_meter
// Description : Decimated loudness envelope for a signed PCM stream. For each
//               accepted sample an FSM optionally removes DC, takes the
//               magnitude and tracks the window peak. At window end an
//               instant-attack / exponential-decay envelope is updated and
//               published as an unsigned level with a one-cycle valid pulse.
// Options     : define DC_BLOCK_EN to build the DC tracker; without it the
//               DC state is still traversed but passes the sample through.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_level_meter #(
  parameter int SAMPLE_DEPTH = 16,
  parameter int DECIMATE     = 400,
  parameter int DC_SHIFT     = 10,
  parameter int DECAY_SHIFT  = 4,
  parameter int LEVEL_DEPTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [SAMPLE_DEPTH-1:0] sample_in,
  input  logic                           sample_strobe,
  input  logic                           clear_flags,
  output logic                           busy,
  output logic        [LEVEL_DEPTH-1:0]  level,
  output logic                           level_valid,
  output logic                           clip,
  output logic                           overrun
);

  localparam int MAG_W = SAMPLE_DEPTH - 1;
  localparam int CNT_W = $clog2(DECIMATE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATE - 1);
  localparam logic signed [SAMPLE_DEPTH-1:0] S_MAX = {1'b0, {(SAMPLE_DEPTH-1){1'b1}}};
  localparam logic signed [SAMPLE_DEPTH-1:0] S_MIN = {1'b1, {(SAMPLE_DEPTH-1){1'b0}}};
  localparam logic [MAG_W-1:0] MAG_MAX = {MAG_W{1'b1}};

  // Elaboration-time parameter legality checks
  if (DECIMATE < 2) begin : g_bad_decimate
    $error("audio_level_meter: DECIMATE must be at least 2");
  end
  if (LEVEL_DEPTH > SAMPLE_DEPTH - 1) begin : g_bad_level_depth
    $error("audio_level_meter: LEVEL_DEPTH must not exceed SAMPLE_DEPTH-1");
  end
  if (DC_SHIFT < 1) begin : g_bad_dc_shift
    $error("audio_level_meter: DC_SHIFT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DC   = 3'd1,
    S_MAG  = 3'd2,
    S_PEAK = 3'd3,
    S_ENV  = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic signed [SAMPLE_DEPTH-1:0]  sample_q, sample_d;
  logic signed [SAMPLE_DEPTH-1:0]  ac_q, ac_d;
  logic        [MAG_W-1:0]         mag_q, mag_d;
  logic        [MAG_W-1:0]         win_max_q, win_max_d;
  logic        [CNT_W-1:0]         win_cnt_q, win_cnt_d;
  logic        [MAG_W-1:0]         env_q, env_d;
  logic        [LEVEL_DEPTH-1:0]   level_q, level_d;
  logic                            level_valid_q, level_valid_d;
  logic                            clip_q, clip_d;
  logic                            overrun_q, overrun_d;

  logic        [MAG_W-1:0]         env_shr;
  logic        [MAG_W-1:0]         env_decay;
  logic        [MAG_W-1:0]         env_next;

`ifdef DC_BLOCK_EN
  localparam int ACC_W = SAMPLE_DEPTH + DC_SHIFT;

  logic signed [ACC_W-1:0]         dc_acc_q, dc_acc_d;
  logic signed [SAMPLE_DEPTH-1:0]  dc_est;
  logic signed [SAMPLE_DEPTH:0]    dc_diff;
  logic signed [ACC_W:0]           acc_sum;
  logic                            ac_ovf;
  logic                            acc_ovf;
  logic signed [SAMPLE_DEPTH-1:0]  ac_sat;
  logic signed [ACC_W-1:0]         acc_sat;

  // DC estimate is the accumulator's integer part; differences are formed one
  // bit wider and saturated back so no path can wrap
  assign dc_est  = dc_acc_q[ACC_W-1:DC_SHIFT];
  assign dc_diff = {sample_q[SAMPLE_DEPTH-1], sample_q} - {dc_est[SAMPLE_DEPTH-1], dc_est};
  assign acc_sum = {dc_acc_q[ACC_W-1], dc_acc_q} + {{DC_SHIFT{dc_diff[SAMPLE_DEPTH]}}, dc_diff};
  assign ac_ovf  = dc_diff[SAMPLE_DEPTH] ^ dc_diff[SAMPLE_DEPTH-1];
  assign acc_ovf = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
  assign ac_sat  = ac_ovf ? (dc_diff[SAMPLE_DEPTH] ? S_MIN : S_MAX) : dc_diff[SAMPLE_DEPTH-1:0];
  assign acc_sat = acc_ovf ? (acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                           : acc_sum[ACC_W-1:0];
`endif

  // Envelope decay step is at least one code so the envelope always reaches 0
  assign env_shr   = env_q >> DECAY_SHIFT;
  assign env_decay = (env_shr == '0) ? MAG_W'(1) : env_shr;
  assign env_next  = (win_max_q >= env_q) ? win_max_q
                   : ((env_q <= env_decay) ? '0 : (env_q - env_decay));

  // Next-state, datapath and sticky-flag logic
  always_comb begin
    state_d       = state_q;
    sample_d      = sample_q;
    ac_d          = ac_q;
    mag_d         = mag_q;
    win_max_d     = win_max_q;
    win_cnt_d     = win_cnt_q;
    env_d         = env_q;
    level_d       = level_q;
    level_valid_d = 1'b0;
    clip_d        = clip_q;
    overrun_d     = overrun_q;
`ifdef DC_BLOCK_EN
    dc_acc_d      = dc_acc_q;
`endif

    // Clear first so any set event in the same cycle takes priority
    if (clear_flags) begin
      clip_d    = 1'b0;
      overrun_d = 1'b0;
    end
    if (sample_strobe && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (sample_strobe) begin
          sample_d = sample_in;
          if ((sample_in == S_MAX) || (sample_in == S_MIN)) begin
            clip_d = 1'b1;
          end
          state_d = S_DC;
        end
      end
      S_DC: begin
`ifdef DC_BLOCK_EN
        ac_d     = ac_sat;
        dc_acc_d = acc_sat;
        if (ac_ovf) begin
          clip_d = 1'b1;
        end
`else
        ac_d = sample_q;
`endif
        state_d = S_MAG;
      end
      S_MAG: begin
        if (ac_q == S_MIN) begin
          mag_d  = MAG_MAX;
          clip_d = 1'b1;
        end else if (ac_q[SAMPLE_DEPTH-1]) begin
          mag_d = ~ac_q[MAG_W-1:0] + 1'b1;
        end else begin
          mag_d = ac_q[MAG_W-1:0];
        end
        state_d = S_PEAK;
      end
      S_PEAK: begin
        if (mag_q > win_max_q) begin
          win_max_d = mag_q;
        end
        if (win_cnt_q == CNT_LAST) begin
          state_d = S_ENV;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_ENV: begin
        env_d         = env_next;
        level_d       = env_next[SAMPLE_DEPTH-2 -: LEVEL_DEPTH];
        level_valid_d = 1'b1;
        win_max_d     = '0;
        win_cnt_d     = '0;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sample_q      <= '0;
      ac_q          <= '0;
      mag_q         <= '0;
      win_max_q     <= '0;
      win_cnt_q     <= '0;
      env_q         <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
      clip_q        <= 1'b0;
      overrun_q     <= 1'b0;
`ifdef DC_BLOCK_EN
      dc_acc_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sample_q      <= sample_d;
      ac_q          <= ac_d;
      mag_q         <= mag_d;
      win_max_q     <= win_max_d;
      win_cnt_q     <= win_cnt_d;
      env_q         <= env_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      clip_q        <= clip_d;
      overrun_q     <= overrun_d;
`ifdef DC_BLOCK_EN
      dc_acc_q      <= dc_acc_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign level       = level_q;
  assign level_valid = level_valid_q;
  assign clip        = clip_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: doc/audio_level_meter.md
Name: audio_level_meter

Overview:
- Consumes the signed PCM stream from the PDM microphone front end and produces a decimated loudness envelope for LED and visualiser logic.
- Per accepted sample, a small FSM removes DC, takes the magnitude, and tracks the window peak.
- At each window end it updates an instant-attack / exponential-decay envelope and outputs it as an unsigned level with a valid pulse.

Parameters:
- SAMPLE_DEPTH, 16: input sample width, signed.
- DECIMATE, 400: accepted samples per output window; minimum 2.
- DC_SHIFT, 10: DC tracker time constant, 2^DC_SHIFT samples.
- DECAY_SHIFT, 4: envelope decay per window, env/2^DECAY_SHIFT.
- LEVEL_DEPTH, 8: output level width; must be ≤ SAMPLE_DEPTH-1.

Ports:
- clk  in  1  system clock (single clock domain).
- rst  in  1  synchronous, active-high reset.
- sample_in  in  SAMPLE_DEPTH  signed audio sample.
- sample_strobe  in  1  sample_in valid this cycle; one sample per high cycle.
- clear_flags  in  1  clears clip and overrun.
- busy  out  1  high when FSM is not in IDLE.
- level  out  LEVEL_DEPTH  envelope, bits [SAMPLE_DEPTH-2 -: LEVEL_DEPTH].
- level_valid  out  1  one-cycle pulse when level updates.
- clip  out  1  sticky: a saturation event occurred.
- overrun  out  1  sticky: a strobe was dropped.

Behaviour:
- Reset: clears state=IDLE, dc_acc, ac, mag, win_max, win_cnt, env, level, level_valid, clip and overrun to 0.
- Reset mid-operation: discards the in-flight sample; no level_valid is produced.
- FSM states: IDLE, DC, MAG, PEAK, ENV.
- IDLE:
  - Strobe sampled at edge k: latch sample_in, go to DC.
- DC, edge k+1:
  - dc_est = dc_acc >>> DC_SHIFT.
  - ac = sat(sample - dc_est) to SAMPLE_DEPTH.
  - dc_acc += sample - dc_est. dc_acc is SAMPLE_DEPTH+DC_SHIFT bits, signed.
  - Go to MAG.
- MAG, edge k+2:
  - mag = |ac|, unsigned SAMPLE_DEPTH-1 bits.
  - ac = most-negative value saturates to 2^(SAMPLE_DEPTH-1)-1 and sets clip.
  - Go to PEAK.
- PEAK, edge k+3:
  - win_max = max(win_max, mag).
  - If win_cnt == DECIMATE-1: go to ENV.
  - Else: win_cnt++, go to IDLE.
- ENV, edge k+4:
  - If win_max ≥ env: env = win_max.
  - Else: env = env - max(env>>DECAY_SHIFT, 1), floored at 0.
  - Clear win_max and win_cnt, update level, assert level_valid for exactly the cycle after edge k+4.
  - Go to IDLE.
- Latency: strobe to level_valid is 4 edges.
  - Accepted throughput: one strobe per 4 cycles, or 5 cycles on a window-end sample.
- Strobe while busy: sample dropped, overrun=1. The dropped sample does not advance win_cnt or touch dc_acc.
- clip is also set when sample_in equals the most-positive or most-negative code.
- Clearing flags:
  - clear_flags clears clip and overrun on the next edge.
  - If clear_flags and a set event occur on the same cycle, set wins.
- Arithmetic: all intermediate subtractions use one extra bit before saturation; no wraparound on any path.
- win_cnt wraps only through ENV. DECIMATE=1 is illegal (elaboration error).

Optional Feature:
- DC_BLOCK_EN defined:
  - DC tracker present as above.
- DC_BLOCK_EN undefined:
  - dc_acc is not instantiated; ac = sample_in.
  - DC state is still traversed, so latency is unchanged.
  - The DC_SHIFT parameter is ignored.

Test Plan:
- Reset: after reset, all outputs = 0, busy=0. Ten cycles with no strobe give no level_valid.
- DECIMATE=4, DC_BLOCK_EN undefined, strobes every 8 cycles with samples 100, -300, 200, 50 -> one level_valid 4 edges after the 4th strobe, env=300, level=2, clip=0.
- DC_BLOCK_EN undefined, DECIMATE=4, four samples of -32768 -> level=255 and clip=1. Next window of four zeros -> env=30720, level=240. clear_flags -> clip=0.
- Back-to-back strobes on adjacent cycles -> second dropped, overrun=1, window closes only after 4 accepted samples.
- DC_BLOCK_EN defined, DC_SHIFT=4, constant 1000 for 200 strobes -> ac magnitude < 8 by the final window, level=0.
- Assert rst in MAG state -> all outputs 0 next cycle, no level_valid, the following window counts from zero.
